// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
// Optional feature macro used by the top level: FND_LEADING_ZERO_BLANK_EN.
package fnd_pkg;

    localparam int unsigned FND_DIGITS  = 4;
    localparam int unsigned NIB_W       = 4;
    localparam int unsigned BIN_W       = 14;
    localparam int unsigned BCD_W       = FND_DIGITS * NIB_W;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned SHIFT_CNT_W = 4;

    localparam logic [NIB_W-1:0]      BCD_DOT     = 4'hA;
    localparam logic [FND_DIGITS-1:0] FND_COM_OFF = 4'b1111;

    // Converter states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Four BCD digits, element 0 is the ones digit
    typedef logic [FND_DIGITS-1:0][NIB_W-1:0] bcd_buf_t;

    // One digit slot as presented to the common lines and the decoder
    typedef struct packed {
        logic [FND_DIGITS-1:0] com;
        logic [NIB_W-1:0]      bcd;
        logic                  blank;
    } scan_out_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic bcd_buf_t bcd_add3(input bcd_buf_t b);
        bcd_buf_t r;
        r = b;
        for (int i = 0; i < FND_DIGITS; i++) begin
            if (b[i] >= NIB_W'(5)) begin
                r[i] = b[i] + NIB_W'(3);
            end
        end
        return r;
    endfunction

    // True when digit n (n > 0) and every digit above it are zero
    function automatic logic lead_zero(input bcd_buf_t b, input logic [IDX_W-1:0] n);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < FND_DIGITS; i++) begin
            if ((i >= int'(n)) && (b[i] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        return (n != '0) && upper_zero;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3, one bit per cycle).
// Start is accepted only in IDLE; o_done is high for the single COMMIT cycle.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    conv_state_e            state_q;
    logic [SHIFT_CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0]       bin_q;
    bcd_buf_t               bcd_q;
    logic                   busy_q;
    logic                   done_q;
    bcd_buf_t               bcd_adj_c;

    // Correction applied to the BCD part before each shift
    always_comb begin
        bcd_adj_c = bcd_add3(bcd_q);
    end

    // Converter FSM with shift register and registered status outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        bin_q   <= i_bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_buf_t'({bcd_adj_c[FND_DIGITS-1:0], bin_q[BIN_W-1]} >> 0);
                    bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                    cnt_q <= cnt_q + SHIFT_CNT_W'(1);
                    if (cnt_q == SHIFT_CNT_W'(BIN_W - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scan controller: binary load -> BCD buffer -> digit multiplex.
// Macro FND_LEADING_ZERO_BLANK_EN: when defined, blanks leading zero digits 1..3.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned VALUE_MAX = 9999
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [BIN_W-1:0]      i_value,
    input  logic                  i_load,
    input  logic                  i_disp_off,
    input  logic [IDX_W-1:0]      i_dot_pos,
    input  logic                  i_dot_en,
    output logic                  o_busy,
    output logic [FND_DIGITS-1:0] o_fnd_com,
    output logic [NIB_W-1:0]      o_bcd,
    output logic                  o_blank
);

    localparam int unsigned     TICK_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam scan_out_t       OUT_RST   = '{com: 4'b1110, bcd: '0, blank: 1'b1};

    logic [BIN_W-1:0] value_sat_c;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic [TICK_W-1:0] tick_q;
    logic [IDX_W-1:0]  idx_q;
    bcd_buf_t          buf_q;
    logic              valid_q;
    scan_out_t         out_q;

    logic              scan_edge_c;
    logic [IDX_W-1:0]  idx_nxt_c;
    logic              dot_hit_c;
    scan_out_t         out_d;

    // Clamp the requested value to the displayable range
    always_comb begin
        value_sat_c = (i_value > BIN_W'(VALUE_MAX)) ? BIN_W'(VALUE_MAX) : i_value;
    end

    bin2bcd_seq u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_load),
        .i_bin   (value_sat_c),
        .o_busy  (o_busy),
        .o_done  (conv_done),
        .o_bcd   (conv_bcd)
    );

    // Display buffer captures each finished conversion
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_q   <= '0;
            valid_q <= 1'b0;
        end else if (conv_done) begin
            buf_q   <= bcd_buf_t'(conv_bcd);
            valid_q <= 1'b1;
        end
    end

    // Slot timer and digit index
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tick_q <= '0;
            idx_q  <= '0;
        end else if (scan_edge_c) begin
            tick_q <= '0;
            idx_q  <= idx_nxt_c;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    // Contents of the digit slot that starts on the next scan edge
    always_comb begin
        scan_edge_c = (tick_q == TICK_LAST);
        idx_nxt_c   = idx_q + IDX_W'(1);
        dot_hit_c   = i_dot_en && (i_dot_pos == idx_nxt_c);
        out_d       = out_q;
        out_d.com   = FND_COM_OFF ^ (FND_DIGITS'(1) << idx_nxt_c);
        out_d.bcd   = dot_hit_c ? BCD_DOT : buf_q[idx_nxt_c];
`ifdef FND_LEADING_ZERO_BLANK_EN
        out_d.blank = i_disp_off || !valid_q ||
                      (lead_zero(buf_q, idx_nxt_c) && !dot_hit_c);
`else
        out_d.blank = i_disp_off || !valid_q;
`endif
    end

    // Output registers change only on scan edges
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_q <= OUT_RST;
        end else if (scan_edge_c) begin
            out_q <= out_d;
        end
    end

    assign o_fnd_com = out_q.com;
    assign o_bcd     = out_q.bcd;
    assign o_blank   = out_q.blank;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with SCAN_DIV=4.
module tb_fnd_scan_controller;

    localparam int unsigned SCAN_DIV = 4;

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        disp_off;
    logic [1:0]  dot_pos;
    logic        dot_en;
    logic        busy;
    logic [3:0]  fnd_com;
    logic [3:0]  bcd;
    logic        blank;

    int n_checks = 0;
    int n_fail   = 0;

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .VALUE_MAX(9999)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_value    (value),
        .i_load     (load),
        .i_disp_off (disp_off),
        .i_dot_pos  (dot_pos),
        .i_dot_en   (dot_en),
        .o_busy     (busy),
        .o_fnd_com  (fnd_com),
        .o_bcd      (bcd),
        .o_blank    (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_slot();
        logic [3:0] prev;
        int k;
        prev = fnd_com;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (fnd_com == prev && k < 3 * SCAN_DIV);
        chk("slot_change", 32'(fnd_com != prev), 32'd1);
    endtask

    task automatic frame(input string tag, input logic [15:0] exp_bcd, input logic [3:0] exp_blank);
        int n0;
        int n;
        logic [3:0] ec;
        wait_slot();
        n0 = 0;
        for (int i = 0; i < 4; i++) if (fnd_com[i] == 1'b0) n0 = i;
        for (int s = 0; s < 4; s++) begin
            n  = (n0 + s) % 4;
            ec = 4'b0001 << n;
            ec = ~ec;
            chk($sformatf("%s_com%0d", tag, n), 32'(fnd_com), 32'(ec));
            chk($sformatf("%s_bcd%0d", tag, n), 32'(bcd), 32'(exp_bcd[n*4 +: 4]));
            chk($sformatf("%s_blank%0d", tag, n), 32'(blank), 32'(exp_blank[n]));
            if (s < 3) wait_slot();
        end
    endtask

    initial begin
        logic [3:0] ec;
        int idx;
        rst      = 1'b1;
        value    = '0;
        load     = 1'b0;
        disp_off = 1'b0;
        dot_pos  = '0;
        dot_en   = 1'b0;

        // Reset state
        #22;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_com", 32'(fnd_com), 32'he);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Scan cycling with empty buffer
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            idx = (c / 4) % 4;
            ec  = 4'b0001 << idx;
            ec  = ~ec;
            chk($sformatf("scan_com_c%0d", c), 32'(fnd_com), 32'(ec));
            chk($sformatf("scan_blank_c%0d", c), 32'(blank), 32'd1);
        end

        // Load 1234 and check busy window
        do_load(14'd1234);
        chk("busy_k0", 32'(busy), 32'd1);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            chk($sformatf("busy_k%0d", i), 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("busy_k15", 32'(busy), 32'd0);
        frame("v1234", 16'h1234, 4'b0000);

        // Saturation and ignored load while busy
        do_load(14'd15000);
        repeat (3) @(negedge clk);
        chk("sat_busy", 32'(busy), 32'd1);
        do_load(14'd5);
        wait_idle();
        frame("v9999", 16'h9999, 4'b0000);
        chk("ignored_load", 32'(busy), 32'd0);

        // Dot substitution on digit 2
        dot_en  = 1'b1;
        dot_pos = 2'd2;
        do_load(14'd42);
        wait_idle();
        frame("v42dot", 16'h0A42, LZ ? 4'b1000 : 4'b0000);
        dot_en = 1'b0;

        // Zero value
        do_load(14'd0);
        wait_idle();
        frame("v0", 16'h0000, LZ ? 4'b1110 : 4'b0000);

        // Display off blanks every digit
        disp_off = 1'b1;
        frame("off", 16'h0000, 4'b1111);
        disp_off = 1'b0;

        // Asynchronous reset during a conversion
        do_load(14'd9999);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_blank", 32'(blank), 32'd1);
        chk("arst_com", 32'(fnd_com), 32'he);
        chk("arst_bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_load(14'd7);
        wait_idle();
        frame("v7", 16'h0007, LZ ? 4'b1110 : 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
